// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the pipe_stage_reg stage register.
// Optional statistics counters are built when PIPE_STAGE_STAT_EN is defined.
package pipe_stage_reg_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;  // addi x0,x0,0
  localparam int          REG_BUS_W = 32;

  typedef logic [REG_BUS_W-1:0] reg_bus_t;

  typedef enum logic [1:0] {
    PSTG_EMPTY = 2'd0,
    PSTG_ONE   = 2'd1,
    PSTG_FULL  = 2'd2
  } pstg_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake, control and statistics bundle for pipe_stage_reg.
// master = surrounding pipeline (drives payload, ready, hold, flush); slave = stage.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  import pipe_stage_reg_pkg::*;

  logic              up_valid_i;
  logic              up_ready_o;
  logic [PC_W-1:0]   up_pc_i;
  logic [DATA_W-1:0] up_data_i;
  logic              dn_valid_o;
  logic              dn_ready_i;
  logic [PC_W-1:0]   dn_pc_o;
  logic [DATA_W-1:0] dn_data_o;
  logic              hold_i;
  logic              flush_i;
  reg_bus_t          stall_cnt_o;
  reg_bus_t          flush_cnt_o;

  modport master (
    output up_valid_i, up_pc_i, up_data_i, dn_ready_i, hold_i, flush_i,
    input  up_ready_o, dn_valid_o, dn_pc_o, dn_data_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  up_valid_i, up_pc_i, up_data_i, dn_ready_i, hold_i, flush_i,
    output up_ready_o, dn_valid_o, dn_pc_o, dn_data_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One storage entry (valid, pc, data) of the stage register.
// flush and reset empty the entry and zero its pc; clear empties it but keeps pc.
module pipe_stage_reg_slot #(
  parameter int                DATA_W     = 32,
  parameter int                PC_W       = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic              clear,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      valid <= 1'b0;
      pc    <= '0;
      data  <= BUBBLE_VAL;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= d_pc;
      data  <= d_data;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= BUBBLE_VAL;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, 2-entry skid buffer, hold and flush.
// Define PIPE_STAGE_STAT_EN to build the saturating stall/flush event counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                PC_W       = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = INST_NOP[DATA_W-1:0]
) (
  input logic             clk,
  input logic             rst_n,
  pipe_stage_reg_if.slave bus
);

  pstg_state_e       state_q, state_d;
  logic              main_valid, skid_valid;
  logic [PC_W-1:0]   main_pc, skid_pc;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              up_ready, dn_valid, fire_in, fire_out;
  logic              main_load, main_from_skid, main_clear, skid_load, skid_clear;
  logic [PC_W-1:0]   main_d_pc;
  logic [DATA_W-1:0] main_d_data;

  // Ready depends only on registered skid occupancy and hold, never on dn_ready.
  assign up_ready = !skid_valid && !bus.hold_i;
  assign dn_valid = main_valid && !bus.hold_i;
  assign fire_in  = bus.up_valid_i && up_ready;
  assign fire_out = dn_valid && bus.dn_ready_i;

  assign bus.up_ready_o = up_ready;
  assign bus.dn_valid_o = dn_valid;
  assign bus.dn_pc_o    = main_pc;
  assign bus.dn_data_o  = main_data;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= PSTG_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (bus.flush_i) begin
      state_d = PSTG_EMPTY;
    end else begin
      case (state_q)
        PSTG_EMPTY: begin
          if (fire_in) begin
            state_d   = PSTG_ONE;
            main_load = 1'b1;
          end
        end
        PSTG_ONE: begin
          if (fire_in && fire_out) begin
            main_load = 1'b1;
          end else if (fire_out) begin
            state_d    = PSTG_EMPTY;
            main_clear = 1'b1;
          end else if (fire_in) begin
            state_d   = PSTG_FULL;
            skid_load = 1'b1;
          end
        end
        PSTG_FULL: begin
          if (fire_out) begin
            state_d        = PSTG_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: state_d = PSTG_EMPTY;
      endcase
    end
  end

  assign main_d_pc   = main_from_skid ? skid_pc   : bus.up_pc_i;
  assign main_d_data = main_from_skid ? skid_data : bus.up_data_i;

  pipe_stage_reg_slot #(.DATA_W(DATA_W), .PC_W(PC_W), .BUBBLE_VAL(BUBBLE_VAL)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (bus.flush_i),
    .load   (main_load),
    .clear  (main_clear),
    .d_pc   (main_d_pc),
    .d_data (main_d_data),
    .valid  (main_valid),
    .pc     (main_pc),
    .data   (main_data)
  );

  pipe_stage_reg_slot #(.DATA_W(DATA_W), .PC_W(PC_W), .BUBBLE_VAL(BUBBLE_VAL)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (bus.flush_i),
    .load   (skid_load),
    .clear  (skid_clear),
    .d_pc   (bus.up_pc_i),
    .d_data (bus.up_data_i),
    .valid  (skid_valid),
    .pc     (skid_pc),
    .data   (skid_data)
  );

`ifdef PIPE_STAGE_STAT_EN
  reg_bus_t stall_cnt_q, flush_cnt_q;

  function automatic reg_bus_t sat_inc(input reg_bus_t v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (dn_valid && !bus.dn_ready_i) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (bus.flush_i)                 flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
`else
  assign bus.stall_cnt_o = '0;
  assign bus.flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios then randomized traffic,
// checked against a queue-based model of the stage contents.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(32), .PC_W(32)) bus ();

  pipe_stage_reg #(.DATA_W(32), .PC_W(32), .BUBBLE_VAL(32'h0000_0013)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  entry_t      exp_q[$];
  logic [31:0] last_pc = '0;
  int unsigned exp_stall = 0, exp_flush = 0;
  int          n_checks = 0, n_fail = 0;
  int unsigned seq = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: model occupancy equals exp_q size; compares outputs mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        last_pc   = '0;
        exp_stall = 0;
        exp_flush = 0;
      end else begin
        logic ev;
        ev = (exp_q.size() > 0) && !bus.hold_i;
        check("dn_valid", {63'd0, bus.dn_valid_o}, {63'd0, ev});
        check("up_ready", {63'd0, bus.up_ready_o},
              {63'd0, (exp_q.size() < 2) && !bus.hold_i});
        if (exp_q.size() > 0) begin
          check("dn_data", {32'd0, bus.dn_data_o}, {32'd0, exp_q[0].data});
          check("dn_pc",   {32'd0, bus.dn_pc_o},   {32'd0, exp_q[0].pc});
        end else begin
          check("bubble_data", {32'd0, bus.dn_data_o}, 64'h13);
          check("bubble_pc",   {32'd0, bus.dn_pc_o},   {32'd0, last_pc});
        end
`ifdef PIPE_STAGE_STAT_EN
        check("stall_cnt", {32'd0, bus.stall_cnt_o}, {32'd0, exp_stall});
        check("flush_cnt", {32'd0, bus.flush_cnt_o}, {32'd0, exp_flush});
`else
        check("stall_cnt", {32'd0, bus.stall_cnt_o}, 64'd0);
        check("flush_cnt", {32'd0, bus.flush_cnt_o}, 64'd0);
`endif
        if (ev && !bus.dn_ready_i) exp_stall++;
        if (bus.flush_i) begin
          exp_flush++;
          exp_q.delete();
          last_pc = '0;
        end else if (ev && bus.dn_ready_i) begin
          last_pc = exp_q[0].pc;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One cycle of stimulus; an accepted input is pushed just after the monitor samples.
  task automatic tick(input logic v, input logic [31:0] pc, input logic [31:0] d,
                      input logic rdy, input logic hld, input logic fl, input logic rn,
                      output logic acc);
    entry_t e;
    bus.up_valid_i = v;
    bus.up_pc_i    = pc;
    bus.up_data_i  = d;
    bus.dn_ready_i = rdy;
    bus.hold_i     = hld;
    bus.flush_i    = fl;
    rst_n          = rn;
    @(negedge clk);
    #1;
    acc = rn && !fl && v && bus.up_ready_o;
    if (acc) begin
      e.pc   = pc;
      e.data = d;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic rdy, input int n);
    logic acc;
    for (int i = 0; i < n; i++) tick(1'b0, 32'hdead_0000, 32'hbad0_0000, rdy, 1'b0, 1'b0, 1'b1, acc);
  endtask

  // Presents one new item until accepted (bounded).
  task automatic send(input logic rdy);
    logic acc;
    int   tries;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 20) begin
      tick(1'b1, seq * 4, seq, rdy, 1'b0, 1'b0, 1'b1, acc);
      tries++;
    end
    check("send_accepted", {63'd0, acc}, 64'd1);
    seq++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    bus.up_valid_i = 1'b0;
    bus.up_pc_i    = '0;
    bus.up_data_i  = '0;
    bus.dn_ready_i = 1'b0;
    bus.hold_i     = 1'b0;
    bus.flush_i    = 1'b0;
    rst_n          = 1'b0;
    @(posedge clk); #2;
    tick(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    idle(1'b1, 1);

    // Stream 1..8 at full rate.
    seq = 1;
    for (int i = 0; i < 8; i++) send(1'b1);
    idle(1'b1, 3);

    // Backpressure: A, then B and C while downstream stalls.
    send(1'b1);
    send(1'b0);
    tick(1'b1, seq * 4, seq, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    check("bp_c_blocked", {63'd0, acc}, 64'd0);
    tick(1'b1, seq * 4, seq, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    send(1'b1);
    idle(1'b1, 4);

    // Flush while FULL with a same-cycle input X that must vanish.
    send(1'b0);
    send(1'b0);
    tick(1'b1, 32'h0000_0bad, 32'hbad0_0bad, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    check("flush_dn_valid", {63'd0, bus.dn_valid_o}, 64'd0);
    check("flush_dn_data", {32'd0, bus.dn_data_o}, 64'h13);
    check("flush_dn_pc", {32'd0, bus.dn_pc_o}, 64'd0);
    idle(1'b1, 3);

    // Hold for 3 cycles with one entry and downstream ready.
    send(1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 32'h77, 32'h77, 1'b1, 1'b1, 1'b0, 1'b1, acc);
    idle(1'b1, 3);

    // Reset while FULL, then stream again.
    send(1'b0);
    send(1'b0);
    tick(1'b1, 32'h0000_0bad, 32'hbad0_0bad, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    check("rst_dn_valid", {63'd0, bus.dn_valid_o}, 64'd0);
    check("rst_up_ready", {63'd0, bus.up_ready_o}, 64'd1);
    check("rst_dn_data", {32'd0, bus.dn_data_o}, 64'h13);
    check("rst_dn_pc", {32'd0, bus.dn_pc_o}, 64'd0);
    for (int i = 0; i < 4; i++) send(1'b1);
    idle(1'b1, 3);

    // Counters: 5 backpressured cycles, then 2 flushes with ready high.
    send(1'b0);
    idle(1'b0, 5);
    tick(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1, acc);
    tick(1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1, acc);
`ifdef PIPE_STAGE_STAT_EN
    check("stat_stall_5", {32'd0, bus.stall_cnt_o}, 64'd5);
    check("stat_flush_2", {32'd0, bus.flush_cnt_o}, 64'd2);
`else
    check("stat_stall_off", {32'd0, bus.stall_cnt_o}, 64'd0);
    check("stat_flush_off", {32'd0, bus.flush_cnt_o}, 64'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic v, rdy, hld, fl, rn;
      v   = ($urandom_range(0, 99) < 65);
      rdy = ($urandom_range(0, 99) < 70);
      hld = ($urandom_range(0, 99) < 10);
      fl  = ($urandom_range(0, 99) < 3);
      rn  = ($urandom_range(0, 199) != 0);
      tick(v, seq * 4, $urandom, rdy, hld, fl, rn, acc);
      if (acc) seq++;
    end

    idle(1'b1, 5);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
